pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter and run-control stage directly upstream of the R-format CPU datapath.
- Holds the architectural PC and drives it as the CPU's instruction address.
- Captures the CPU's computed next address each clock and commits it into the PC.
- Detects program end, misalignment and stalls; counts retired instructions. Purely sequential control; no datapath arithmetic beyond compare and count.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on start.
- END_ADDR, 32'h0000_0100, first address past the program; fetching at or beyond it ends the run.
- WDT_LIMIT, 1024, watchdog cycle limit in RUN; used only with WATCHDOG_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run from RESET_PC.
- stall  input  1  when high in RUN, PC and counter hold.
- next_addr  input  32  next PC from the CPU datapath.
- pc  output  32  current PC; wired to the CPU instruction address.
- running  output  1  high while in RUN.
- halted  output  1  high in DONE.
- error  output  1  high in FAULT.
- retired  output  32  instructions committed this run.
- fault_pc  output  32  PC at which the fault occurred.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pc=RESET_PC, retired=0, fault_pc=0.
  - running, halted and error all 0.
  - Reset asserted mid-run aborts immediately. No partial commit.
- States: IDLE, RUN, DONE, FAULT. Outputs are registered or decoded from state only; no combinational path from next_addr to any output.
- IDLE:
  - start=1 → RUN; pc=RESET_PC; retired=0.
- RUN, per rising edge, in priority order:
  1. stall=1: hold pc and retired; stay RUN.
  2. next_addr[1:0]!=0: → FAULT; fault_pc=pc; pc holds.
  3. next_addr==pc (jump-to-self idiom): → DONE; retired+1; pc holds.
  4. next_addr>=END_ADDR (unsigned): → DONE; retired+1; pc=next_addr.
  5. Otherwise: pc=next_addr; retired+1; stay RUN.
- Commit latency: next_addr is visible on pc exactly one cycle after it is sampled.
- The instruction at pc executes in the same cycle it is presented, so the CPU's register and data-memory writes stay one per cycle.
- The CPU is not gated. Stall-cycle writes are the integrator's responsibility.
- Reaching DONE via rule 4 counts the last instruction. Rule 3 counts the self-jump once.
- DONE and FAULT:
  - Hold all outputs.
  - start=1 → RUN with pc=RESET_PC, retired=0. fault_pc is cleared only on reset.
- start is ignored while in RUN. start and stall asserted together in IDLE: start wins; the stall applies from the next cycle.
- retired wraps 32'hFFFF_FFFF→0 silently.
- pc wrap: next_addr 32'hFFFF_FFFC→0 is legal if below END_ADDR. It is committed normally.
- RESET_PC>=END_ADDR: the first RUN edge goes to DONE after one retire.

Optional Feature:
- Macro: PC_SEQUENCER_WATCHDOG_EN.
- Defined:
  - A cycle counter counts every RUN cycle, stalled or not; it clears on entering RUN.
  - When the count reaches WDT_LIMIT, the state goes to FAULT with fault_pc=pc. This has priority over rules 1–5 on that edge.
- Undefined: no counter is built, WDT_LIMIT is unused, and RUN can last indefinitely.

Test Plan:
- Reset then start; drive next_addr=pc+4 each cycle with END_ADDR=0x100 → pc steps 0,4,…,0xFC. On the 64th edge pc=0x100, halted=1, retired=64.
- At pc=0x10 drive next_addr=0x10 → DONE; halted=1, retired=5, pc stays 0x10.
- At pc=0x08 drive next_addr=0x0E → error=1, fault_pc=0x08, pc=0x08, retired=2. A subsequent start gives pc=0, running=1, retired=0.
- In RUN at pc=0x20 hold stall=1 for 3 cycles with next_addr=0x40 → pc=0x20 and retired unchanged. After stall drops, the next edge gives pc=0x40.
- Assert rst asynchronously mid-cycle at pc=0x30 → pc=0 and running=0 before the next clk edge. start is required to resume.
- With PC_SEQUENCER_WATCHDOG_EN and WDT_LIMIT=8, drive a loop 0x0↔0x4 → error=1 on the 8th RUN edge, fault_pc=0x0 or 0x4 per parity. Without the macro, the loop runs for 100 cycles with no fault.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter and run-control stage sitting in front of the R-format CPU
// datapath. It holds the architectural PC, presents it as the instruction
// address, and commits the CPU's computed next address once per clock while
// in RUN. It detects program end, misaligned targets and stalls, and it
// counts retired instructions.
//
// Optional feature: define PC_SEQUENCER_WATCHDOG_EN to build a RUN-cycle
// watchdog that forces FAULT after WDT_LIMIT RUN cycles. With the macro
// undefined no counter is built and WDT_LIMIT is unused.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle pulse, begins a run from RESET_PC
//   stall      in   holds pc and retired while in RUN
//   next_addr  in   [31:0] next PC computed by the CPU datapath
//   pc         out  [31:0] current PC / CPU instruction address
//   running    out  high in RUN
//   halted     out  high in DONE
//   error      out  high in FAULT
//   retired    out  [31:0] instructions committed this run (wraps)
//   fault_pc   out  [31:0] PC at which the last fault occurred
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] END_ADDR  = 32'h0000_0100,
    parameter int unsigned WDT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic [31:0] next_addr,
    output logic [31:0] pc,
    output logic        running,
    output logic        halted,
    output logic        error,
    output logic [31:0] retired,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        wdt_fire;

`ifdef PC_SEQUENCER_WATCHDOG_EN
    // Counts RUN edges already taken; the edge that would make the count
    // reach WDT_LIMIT is the one that faults.
    logic [31:0] wdt_q, wdt_d;
    assign wdt_fire = (wdt_q == 32'(WDT_LIMIT - 1));
`else
    assign wdt_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            retired_q  <= '0;
            fault_pc_q <= '0;
`ifdef PC_SEQUENCER_WATCHDOG_EN
            wdt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            fault_pc_q <= fault_pc_d;
`ifdef PC_SEQUENCER_WATCHDOG_EN
            wdt_q      <= wdt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        retired_d  = retired_q;
        fault_pc_d = fault_pc_q;
`ifdef PC_SEQUENCER_WATCHDOG_EN
        wdt_d      = wdt_q;
`endif
        case (state_q)
            RUN: begin
`ifdef PC_SEQUENCER_WATCHDOG_EN
                wdt_d = wdt_q + 32'd1;
`endif
                if (wdt_fire) begin
                    state_d    = FAULT;
                    fault_pc_d = pc_q;
                end else if (stall) begin
                    // hold everything
                end else if (next_addr[1:0] != 2'b00) begin
                    state_d    = FAULT;
                    fault_pc_d = pc_q;
                end else if (next_addr == pc_q) begin
                    // jump-to-self: the self-jump retires once, pc stays
                    state_d   = DONE;
                    retired_d = retired_q + 32'd1;
                end else if (next_addr >= END_ADDR) begin
                    state_d   = DONE;
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_addr;
                end else begin
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_addr;
                end
            end
            default: begin
                // IDLE, DONE and FAULT all restart the same way; fault_pc
                // survives a restart and is only cleared by reset.
                if (start) begin
                    state_d   = RUN;
                    pc_d      = RESET_PC;
                    retired_d = '0;
`ifdef PC_SEQUENCER_WATCHDOG_EN
                    wdt_d     = '0;
`endif
                end
            end
        endcase
    end

    assign pc       = pc_q;
    assign retired  = retired_q;
    assign fault_pc = fault_pc_q;
    assign running  = (state_q == RUN);
    assign halted   = (state_q == DONE);
    assign error    = (state_q == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] END_ADDR = 32'h100;
`ifdef PC_SEQUENCER_WATCHDOG_EN
    localparam int unsigned WDT_LIMIT = 8;
`else
    localparam int unsigned WDT_LIMIT = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] next_addr = '0;
    logic [31:0] pc, retired, fault_pc;
    logic        running, halted, error;

    int checks = 0;
    int errors = 0;

    // Reference model: plain run/done/fault flags and counters.
    bit          m_run, m_done, m_fault;
    logic [31:0] m_pc, m_ret, m_fpc;
    int unsigned m_cycles;

    pc_sequencer #(.RESET_PC(RESET_PC), .END_ADDR(END_ADDR), .WDT_LIMIT(WDT_LIMIT)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .next_addr(next_addr),
        .pc(pc), .running(running), .halted(halted), .error(error),
        .retired(retired), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_fault = 0;
        m_pc = RESET_PC; m_ret = 0; m_fpc = 0; m_cycles = 0;
    endtask

    task automatic model_step(input bit st, input bit sl, input logic [31:0] na);
        if (!m_run) begin
            if (st) begin
                m_run = 1; m_done = 0; m_fault = 0;
                m_pc = RESET_PC; m_ret = 0; m_cycles = 0;
            end
            return;
        end
`ifdef PC_SEQUENCER_WATCHDOG_EN
        m_cycles++;
        if (m_cycles >= WDT_LIMIT) begin
            m_run = 0; m_fault = 1; m_fpc = m_pc;
            return;
        end
`endif
        if (sl) return;
        if (na % 4 != 0) begin
            m_run = 0; m_fault = 1; m_fpc = m_pc;
        end else if (na == m_pc) begin
            m_run = 0; m_done = 1; m_ret = m_ret + 1;
        end else begin
            m_ret = m_ret + 1;
            m_pc  = na;
            if (na >= END_ADDR) begin m_run = 0; m_done = 1; end
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".pc"},       pc,       m_pc);
        cmp({tag, ".running"},  {31'd0, running}, {31'd0, m_run});
        cmp({tag, ".halted"},   {31'd0, halted},  {31'd0, m_done});
        cmp({tag, ".error"},    {31'd0, error},   {31'd0, m_fault});
        cmp({tag, ".retired"},  retired,  m_ret);
        cmp({tag, ".fault_pc"}, fault_pc, m_fpc);
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising.
    task automatic cyc(input string tag, input bit st, input bit sl, input logic [31:0] na);
        @(negedge clk);
        start = st; stall = sl; next_addr = na;
        model_step(st, sl, na);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] na;
        int r;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk); rst = 1'b0;
        cyc("idle_hold", 0, 0, 32'h44);

        // Straight-line program to END_ADDR
        cyc("t1_start", 1, 0, 32'h0);
        for (int i = 0; i < 64; i++) cyc("t1_step", 0, 0, m_pc + 32'd4);
`ifndef PC_SEQUENCER_WATCHDOG_EN
        cmp("t1_pc_end", pc, 32'h100);
        cmp("t1_halted", {31'd0, halted}, 32'd1);
        cmp("t1_retired", retired, 32'd64);
`endif

        // Jump-to-self at 0x10
        cyc("t2_start", 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) cyc("t2_step", 0, 0, m_pc + 32'd4);
        cyc("t2_self", 0, 0, 32'h10);
        cmp("t2_pc", pc, 32'h10);
        cmp("t2_halted", {31'd0, halted}, 32'd1);
        cmp("t2_retired", retired, 32'd5);

        // Misaligned target at 0x08, then restart
        cyc("t3_start", 1, 0, 32'h0);
        for (int i = 0; i < 2; i++) cyc("t3_step", 0, 0, m_pc + 32'd4);
        cyc("t3_misalign", 0, 0, 32'h0E);
        cmp("t3_error", {31'd0, error}, 32'd1);
        cmp("t3_fault_pc", fault_pc, 32'h08);
        cmp("t3_pc", pc, 32'h08);
        cmp("t3_retired", retired, 32'd2);
        cyc("t3_restart", 1, 0, 32'h0);
        cmp("t3_re_pc", pc, 32'h0);
        cmp("t3_re_running", {31'd0, running}, 32'd1);
        cmp("t3_re_retired", retired, 32'd0);
        cmp("t3_fault_pc_kept", fault_pc, 32'h08);

        // Stall for 3 cycles at 0x20 (start+stall from idle: start wins)
        cyc("t4_halt", 0, 0, m_pc);
        cyc("t4_start_stall", 1, 1, 32'h0);
        for (int i = 0; i < 8; i++) cyc("t4_step", 0, 0, m_pc + 32'd4);
        for (int i = 0; i < 3; i++) cyc("t4_stall", 0, 1, 32'h40);
`ifndef PC_SEQUENCER_WATCHDOG_EN
        cmp("t4_pc_held", pc, 32'h20);
        cmp("t4_ret_held", retired, 32'd8);
`endif
        cyc("t4_release", 0, 0, 32'h40);
`ifndef PC_SEQUENCER_WATCHDOG_EN
        cmp("t4_pc_commit", pc, 32'h40);
`endif

        // Asynchronous reset mid-cycle
        cyc("t5_start", 1, 0, 32'h0);
        for (int i = 0; i < 12; i++) cyc("t5_step", 0, 0, m_pc + 32'd4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        cmp("t5_async_pc", pc, 32'h0);
        cmp("t5_async_running", {31'd0, running}, 32'd0);
        check_all("t5_async");
        @(negedge clk); rst = 1'b0;
        cyc("t5_no_resume", 0, 0, 32'h4);
        cmp("t5_idle", {31'd0, running}, 32'd0);

        // 0 <-> 4 loop
        cyc("t6_start", 1, 0, 32'h0);
`ifdef PC_SEQUENCER_WATCHDOG_EN
        for (int i = 0; i < 8; i++) cyc("t6_loop", 0, 0, (m_pc == 0) ? 32'h4 : 32'h0);
        cmp("t6_wdt_error", {31'd0, error}, 32'd1);
        cmp("t6_wdt_fpc", fault_pc, 32'h4);
        cmp("t6_wdt_ret", retired, 32'd7);
`else
        for (int i = 0; i < 100; i++) cyc("t6_loop", 0, 0, (m_pc == 0) ? 32'h4 : 32'h0);
        cmp("t6_no_error", {31'd0, error}, 32'd0);
        cmp("t6_running", {31'd0, running}, 32'd1);
        cmp("t6_retired", retired, 32'd100);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 19);
            case (r)
                0:       na = m_pc + 32'($urandom_range(1, 3));
                1:       na = m_pc;
                2:       na = {$urandom} & 32'hFFFF_FFFC;
                3:       na = $urandom;
                4, 5:    na = {24'd0, 8'($urandom)} & 32'hFFFF_FFFC;
                default: na = m_pc + 32'd4;
            endcase
            cyc("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), na);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
